// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: round-robin shared bit-serial subtractor, LSB first, one bit per clock
// Computes d = (x - y - bin) mod 2^WIDTH and the final borrow for one of two requesters.
// Ports: clk, rst_n (async active-low); req0/x0/y0/bin0 and req1/x1/y1/bin1 requester inputs;
//        gnt0/gnt1 grant pulses, busy, done pulse, done_id owner, d difference, bout borrow.
// Optional: define SERIAL_SUB_FLAGS_EN to add the zero and ovf (signed overflow) outputs.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic             bin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             bin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, r_q, r_d, d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic b_q, b_d, owner_q, owner_d, last_q, last_d;
    logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, busy_q, busy_d;
    logic done_q, done_d, done_id_q, done_id_d, bout_q, bout_d;
    logic dbit, bbit, win;
`ifdef SERIAL_SUB_FLAGS_EN
    logic zero_q, zero_d, ovf_q, ovf_d;
`endif
    always_comb begin
        dbit = x_q[0] ^ y_q[0] ^ b_q;
        bbit = (~x_q[0] & y_q[0]) | (b_q & (~x_q[0] | y_q[0]));
        // on a tie the requester not granted last wins
        win = (req0 & req1) ? ~last_q : req1;
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        r_d = r_q;
        b_d = b_q;
        cnt_d = cnt_q;
        owner_d = owner_q;
        last_d = last_q;
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        done_d = 1'b0;
        done_id_d = done_id_q;
        d_d = d_q;
        bout_d = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
        zero_d = zero_q;
        ovf_d = ovf_q;
`endif
        case (state_q)
            IDLE: if (req0 | req1) begin
                state_d = RUN;
                x_d = win ? x1 : x0;
                y_d = win ? y1 : y0;
                b_d = win ? bin1 : bin0;
                cnt_d = '0;
                owner_d = win;
                last_d = win;
                gnt0_d = ~win;
                gnt1_d = win;
            end
            RUN: begin
                x_d = x_q >> 1;
                y_d = y_q >> 1;
                r_d = {dbit, r_q[WIDTH-1:1]};
                b_d = bbit;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // results are loaded on the last bit edge so they are visible in DONE
                    state_d = DONE;
                    done_d = 1'b1;
                    done_id_d = owner_q;
                    d_d = r_d;
                    bout_d = bbit;
`ifdef SERIAL_SUB_FLAGS_EN
                    zero_d = (r_d == '0);
                    ovf_d = b_q ^ bbit;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            r_q <= '0;
            b_q <= 1'b0;
            cnt_q <= '0;
            owner_q <= 1'b0;
            last_q <= 1'b1;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            done_id_q <= 1'b0;
            d_q <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_q <= 1'b0;
            ovf_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            r_q <= r_d;
            b_q <= b_d;
            cnt_q <= cnt_d;
            owner_q <= owner_d;
            last_q <= last_d;
            gnt0_q <= gnt0_d;
            gnt1_q <= gnt1_d;
            busy_q <= busy_d;
            done_q <= done_d;
            done_id_q <= done_id_d;
            d_q <= d_d;
            bout_q <= bout_d;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_q <= zero_d;
            ovf_q <= ovf_d;
`endif
        end
    end
    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign busy = busy_q;
    assign done = done_q;
    assign done_id = done_id_q;
    assign d = d_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign zero = zero_q;
    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed and random checks of serial_sub_ctrl at WIDTH=8
module tb_serial_sub_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, bin0 = 1'b0, bin1 = 1'b0;
    logic [7:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic gnt0, gnt1, busy, done, done_id, bout;
    logic [7:0] d;
`ifdef SERIAL_SUB_FLAGS_EN
    logic zero, ovf;
`endif
    int errors = 0, checks = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .x0(x0), .y0(y0), .bin0(bin0),
        .req1(req1), .x1(x1), .y1(y1), .bin1(bin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .d(d), .bout(bout)
`ifdef SERIAL_SUB_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Issue one operation from an idle controller and check grant, latency and result.
    task automatic op(input logic id, input logic [7:0] x, input logic [7:0] y, input logic b,
                      input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        int extra_gnt;
        if (id) begin req1 = 1'b1; x1 = x; y1 = y; bin1 = b; end
        else begin req0 = 1'b1; x0 = x; y0 = y; bin0 = b; end
        tick;
        chk("gnt", 32'({gnt1, gnt0}), id ? 32'd2 : 32'd1);
        chk("busy_gnt", 32'(busy), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        n = 0;
        extra_gnt = 0;
        while (!done && n < 20) begin
            tick;
            n++;
            if (gnt0 | gnt1) extra_gnt++;
        end
        chk("latency", 32'(n), 32'd8);
        chk("extra_gnt", 32'(extra_gnt), 32'd0);
        chk("d", 32'(d), 32'(ed));
        chk("bout", 32'(bout), 32'(eb));
        chk("done_id", 32'(done_id), 32'(id));
        chk("busy_done", 32'(busy), 32'd1);
`ifdef SERIAL_SUB_FLAGS_EN
        chk("zero", 32'(zero), 32'(ed == 8'h00));
        chk("ovf", 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unreachable");
`endif
        tick;
        chk("idle", 32'({done, busy, gnt0, gnt1}), 32'd0);
        chk("d_held", 32'(d), 32'(ed));
    endtask

    initial begin
        logic [8:0] e;
        int s, n;
        logic id, b;
        logic [7:0] x, y;
        logic [1:0] ids [3];
        logic [7:0] tie_d [3];
        ids = '{2'd0, 2'd1, 2'd0};
        tie_d = '{8'h22, 8'hFC, 8'h22};
        #1;
        chk("reset_outs", 32'({gnt0, gnt1, busy, done, done_id, bout, d}), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        // both requesting from reset: 0 wins the first tie, then alternation
        req0 = 1'b1; x0 = 8'h33; y0 = 8'h11; bin0 = 1'b0;
        req1 = 1'b1; x1 = 8'h05; y1 = 8'h09; bin1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("tie_gnt", 32'({gnt1, gnt0}), ids[k] == 2'd1 ? 32'd2 : 32'd1);
            n = 0;
            for (int j = 0; j < 8; j++) begin
                tick;
                if (gnt0 | gnt1) n++;
            end
            chk("tie_no_gnt", 32'(n), 32'd0);
            chk("tie_done", 32'(done), 32'd1);
            chk("tie_id", 32'(done_id), 32'(ids[k][0]));
            chk("tie_d", 32'(d), 32'(tie_d[k]));
            tick;
            chk("tie_idle", 32'({busy, gnt0, gnt1}), 32'd0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick;
        op(1'b0, 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        op(1'b1, 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        op(1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op(1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        op(1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
        // reset four cycles into RUN: outputs clear asynchronously, no done appears
        req0 = 1'b1; x0 = 8'hC3; y0 = 8'h3C; bin0 = 1'b0;
        tick;
        req0 = 1'b0;
        for (int j = 0; j < 4; j++) tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'({gnt0, gnt1, busy, done, done_id, bout, d}), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        n = 0;
        for (int j = 0; j < 12; j++) begin
            tick;
            if (done | busy) n++;
        end
        chk("no_done_after_rst", 32'(n), 32'd0);
        op(1'b1, 8'hA0, 8'h0B, 1'b1, 8'h94, 1'b0, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            id = 1'($urandom_range(0, 1));
            x = 8'($urandom);
            y = 8'($urandom);
            b = 1'($urandom_range(0, 1));
            e = {1'b0, x} - {1'b0, y} - {8'd0, b};
            s = int'($signed(x)) - int'($signed(y)) - int'(b);
            op(id, x, y, b, e[7:0], e[8], (s < -128) || (s > 127));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
